// File: rtl/tinker_fetch_queue.sv
// tinker_fetch_queue
//   Fetch stage for the Tinker core. It owns the PC and issues one instruction read
//   at a time to a variable-latency memory over a req/ack handshake. Fetched words
//   go into a DEPTH-entry prefetch FIFO, which feeds decode over valid/ready. A
//   redirect flushes the FIFO, and any response still in flight is discarded.
//
// Ports
//   clk, reset         clock; asynchronous active-high reset
//   redirect           branch taken this cycle: flush the FIFO and refetch
//   redirect_pc        redirect target; bits [1:0] are ignored (forced to 0)
//   imem_req           registered read request; live in REQ and DROP
//   imem_addr          registered request address; stable while imem_req=1
//   imem_ack           memory accepted the request; imem_rdata is valid this cycle
//   imem_rdata         returned instruction word
//   instr_valid        FIFO head holds an instruction
//   instr, instr_pc    head word and its PC; both 0 when instr_valid=0
//   instr_ready        decode consumes the head when instr_valid & instr_ready
//   fifo_count         number of occupied FIFO entries
module tinker_fetch_queue #(
    parameter int unsigned ADDR_W   = 64,
    parameter int unsigned INSTR_W  = 32,
    parameter int unsigned DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h2000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       redirect,
    input  logic [ADDR_W-1:0]          redirect_pc,
    output logic                       imem_req,
    output logic [ADDR_W-1:0]          imem_addr,
    input  logic                       imem_ack,
    input  logic [INSTR_W-1:0]         imem_rdata,
    output logic                       instr_valid,
    output logic [INSTR_W-1:0]         instr,
    output logic [ADDR_W-1:0]          instr_pc,
    input  logic                       instr_ready,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);

    localparam logic [ADDR_W-1:0] RESET_ADDR = RESET_PC[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);
    localparam logic [CW-1:0]     DEPTH_C    = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [ADDR_W-1:0]   fetch_pc_q;
    logic [ADDR_W-1:0]   fetch_pc_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   addr_d;
    logic                req_q;
    logic                req_d;
    logic [CW-1:0]       count_q;
    logic [CW-1:0]       count_d;
    logic [CW-1:0]       count_after;
    logic [PW-1:0]       wptr_q;
    logic [PW-1:0]       rptr_q;
    logic                push;
    logic                pop;
    logic [ADDR_W-1:0]   redirect_target;

    logic [ADDR_W-1:0]   mem_pc   [DEPTH];
    logic [INSTR_W-1:0]  mem_data [DEPTH];

    // Redirect wins over both push and pop in the same cycle.
    assign push = (state_q == REQ) && imem_ack && !redirect;
    assign pop  = (count_q != '0) && instr_ready && !redirect;

    // Occupancy after this cycle's push/pop, ignoring any flush; used to decide
    // whether another back-to-back request still has room for its response.
    assign count_after = count_q + CW'(push) - CW'(pop);

    assign redirect_target = {redirect_pc[ADDR_W-1:2], 2'b00};

    // ------------------------------------------------------------------
    // State register and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_ADDR;
            addr_q     <= RESET_ADDR;
            req_q      <= 1'b0;
            count_q    <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            req_q      <= req_d;
            count_q    <= count_d;
            if (redirect) begin
                wptr_q <= '0;
                rptr_q <= '0;
            end else begin
                if (push) wptr_q <= wptr_q + PW'(1);
                if (pop)  rptr_q <= rptr_q + PW'(1);
            end
        end
    end

    // Storage needs no reset: the head is masked to 0 whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wptr_q]   <= addr_q;
            mem_data[wptr_q] <= imem_rdata;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (!redirect && (count_q < DEPTH_C)) state_d = REQ;
            end
            REQ: begin
                if (redirect)                                  state_d = imem_ack ? IDLE : DROP;
                else if (imem_ack && !(count_after < DEPTH_C)) state_d = IDLE;
            end
            DROP: begin
                // A redirect with no ack keeps waiting for the stale response.
                if (imem_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Registered-output / datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        req_d      = (state_d != IDLE);
        count_d    = redirect ? '0 : count_after;
        if (redirect) begin
            fetch_pc_d = redirect_target;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (state_d == REQ) addr_d = fetch_pc_q;
                end
                REQ: begin
                    if (imem_ack) begin
                        fetch_pc_d = addr_q + PC_STEP;
                        if (state_d == REQ) addr_d = addr_q + PC_STEP;
                    end
                end
                default: ;
            endcase
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign fifo_count  = count_q;
    assign instr_valid = (count_q != '0);
    assign instr       = instr_valid ? mem_data[rptr_q] : '0;
    assign instr_pc    = instr_valid ? mem_pc[rptr_q]   : '0;

    // Requests only issue when their response has a free slot, so a push never overflows.
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push && !pop && (count_q == DEPTH_C)));
    a_count_bound: assert property (@(posedge clk) disable iff (reset)
        count_q <= DEPTH_C);

endmodule

// File: tb/tb_tinker_fetch_queue.sv
module tb_tinker_fetch_queue;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic        instr_ready;
    logic [2:0]  fifo_count;

    tinker_fetch_queue #(
        .ADDR_W  (64),
        .INSTR_W (32),
        .DEPTH   (DEPTH),
        .RESET_PC(64'h2000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .instr_valid(instr_valid),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .instr_ready(instr_ready),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    // Behavioural model: FIFO contents as a queue plus the single outstanding request.
    typedef struct {
        logic [63:0] pc;
        logic [31:0] data;
    } ent_t;

    ent_t        mq[$];
    logic        m_busy;     // a request is live on the bus
    logic        m_drop;     // its response must be thrown away
    logic [63:0] m_addr;     // address presented on the bus
    logic [63:0] m_fetch;    // where the next fresh request starts

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_busy  = 1'b0;
        m_drop  = 1'b0;
        m_addr  = 64'h2000;
        m_fetch = 64'h2000;
    endtask

    // Applies the spec rules for one rising edge, using the inputs seen at that edge.
    task automatic model_edge();
        int sz0;
        sz0 = mq.size();
        if (redirect) begin
            mq.delete();
            m_fetch = {redirect_pc[63:2], 2'b00};
            if (m_busy && !imem_ack) m_drop = 1'b1;
            else begin
                m_busy = 1'b0;
                m_drop = 1'b0;
            end
        end else begin
            if (sz0 > 0 && instr_ready) mq.delete(0);
            if (m_busy && imem_ack) begin
                if (m_drop) begin
                    m_busy = 1'b0;
                    m_drop = 1'b0;
                end else begin
                    mq.push_back('{pc: m_addr, data: imem_rdata});
                    m_fetch = m_addr + 64'd4;
                    if (mq.size() < DEPTH) m_addr = m_addr + 64'd4;
                    else                   m_busy = 1'b0;
                end
            end else if (!m_busy && sz0 < DEPTH) begin
                m_busy = 1'b1;
                m_addr = m_fetch;
            end
        end
    endtask

    task automatic compare_all();
        chk("imem_req",    {63'd0, imem_req},    {63'd0, m_busy});
        chk("imem_addr",   imem_addr,            m_addr);
        chk("fifo_count",  {61'd0, fifo_count},  64'(mq.size()));
        chk("instr_valid", {63'd0, instr_valid}, {63'd0, (mq.size() != 0)});
        chk("instr",       {32'd0, instr},       (mq.size() != 0) ? {32'd0, mq[0].data} : 64'd0);
        chk("instr_pc",    instr_pc,             (mq.size() != 0) ? mq[0].pc : 64'd0);
    endtask

    // One clock: drive inputs, let the edge happen, update model, check on the falling edge.
    task automatic step(input logic ack, input logic [31:0] rd, input logic rdy,
                        input logic rdr, input logic [63:0] rpc);
        imem_ack    = ack;
        imem_rdata  = rd;
        instr_ready = rdy;
        redirect    = rdr;
        redirect_pc = rpc;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        imem_ack    = 1'b0;
        imem_rdata  = '0;
        instr_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        model_reset();
        compare_all();
        chk("reset_instr_pc_zero", instr_pc, 64'd0);
        reset = 1'b0;
    endtask

    initial begin
        do_reset();

        // Zero-wait memory, decode always ready: one instruction per cycle.
        step(1'b1, $urandom, 1'b1, 1'b0, '0);
        chk("lit_first_req", {63'd0, imem_req}, 64'd1);
        chk("lit_first_addr", imem_addr, 64'h2000);
        step(1'b1, $urandom, 1'b1, 1'b0, '0);
        chk("lit_pc0", instr_pc, 64'h2000);
        step(1'b1, $urandom, 1'b1, 1'b0, '0);
        chk("lit_pc1", instr_pc, 64'h2004);
        step(1'b1, $urandom, 1'b1, 1'b0, '0);
        chk("lit_pc2", instr_pc, 64'h2008);

        // Decode stalled: FIFO fills to DEPTH and fetching pauses.
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, $urandom, 1'b0, 1'b0, '0);
        chk("lit_full_count", {61'd0, fifo_count}, 64'd4);
        chk("lit_full_req", {63'd0, imem_req}, 64'd0);
        chk("lit_full_head", instr_pc, 64'h2000);
        step(1'b1, $urandom, 1'b1, 1'b0, '0);
        chk("lit_pop_head1", instr_pc, 64'h2004);
        step(1'b1, $urandom, 1'b1, 1'b0, '0);
        chk("lit_pop_head2", instr_pc, 64'h2008);
        chk("lit_resume_addr", imem_addr, 64'h2010);
        step(1'b1, $urandom, 1'b1, 1'b0, '0);
        chk("lit_pop_head3", instr_pc, 64'h200C);

        // Slow memory with a redirect while waiting: stale response is dropped.
        do_reset();
        step(1'b0, $urandom, 1'b1, 1'b0, '0);
        step(1'b0, $urandom, 1'b1, 1'b0, '0);
        step(1'b0, $urandom, 1'b1, 1'b1, 64'h3000);
        chk("lit_drop_req_live", {63'd0, imem_req}, 64'd1);
        chk("lit_drop_count", {61'd0, fifo_count}, 64'd0);
        step(1'b1, 32'hBAD0BAD0, 1'b1, 1'b0, '0);
        chk("lit_drop_no_push", {63'd0, instr_valid}, 64'd0);
        step(1'b1, $urandom, 1'b1, 1'b0, '0);
        chk("lit_after_drop_addr", imem_addr, 64'h3000);
        step(1'b1, $urandom, 1'b1, 1'b0, '0);
        chk("lit_after_drop_pc", instr_pc, 64'h3000);

        // Redirect to an unaligned target in the same cycle as an ack.
        do_reset();
        step(1'b1, $urandom, 1'b1, 1'b0, '0);
        step(1'b1, $urandom, 1'b1, 1'b0, '0);
        step(1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 64'h3002);
        chk("lit_redir_ack_valid", {63'd0, instr_valid}, 64'd0);
        chk("lit_redir_ack_req", {63'd0, imem_req}, 64'd0);
        step(1'b1, $urandom, 1'b1, 1'b0, '0);
        chk("lit_redir_ack_addr", imem_addr, 64'h3000);

        // Asynchronous reset between edges while a request is live and the FIFO holds data.
        do_reset();
        step(1'b1, $urandom, 1'b0, 1'b0, '0);
        step(1'b1, $urandom, 1'b0, 1'b0, '0);
        step(1'b0, $urandom, 1'b0, 1'b0, '0);
        #2 reset = 1'b1;
        #1;
        chk("lit_async_req", {63'd0, imem_req}, 64'd0);
        chk("lit_async_valid", {63'd0, instr_valid}, 64'd0);
        chk("lit_async_count", {61'd0, fifo_count}, 64'd0);
        model_reset();
        @(negedge clk);
        compare_all();
        reset = 1'b0;
        step(1'b1, $urandom, 1'b1, 1'b0, '0);
        chk("lit_async_restart", imem_addr, 64'h2000);

        // PC wrap at the top of the address space.
        do_reset();
        step(1'b1, $urandom, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
        step(1'b1, $urandom, 1'b1, 1'b0, '0);
        step(1'b1, $urandom, 1'b1, 1'b0, '0);
        chk("lit_wrap_pc0", instr_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        step(1'b1, $urandom, 1'b1, 1'b0, '0);
        chk("lit_wrap_pc1", instr_pc, 64'h0);

        // Randomised traffic: bursty acks, stalls, occasional redirects (some near the wrap).
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic        a;
            logic        r;
            logic        rd;
            logic [63:0] t;
            a  = (i % 400 < 100) ? 1'b1 : ($urandom_range(0, 2) != 0);
            r  = ($urandom_range(0, 3) != 0);
            rd = ($urandom_range(0, 31) == 0);
            t  = ($urandom_range(0, 3) == 0) ? {32'hFFFF_FFFF, 28'hFFFFFFF, 4'($urandom)}
                                             : {$urandom, $urandom};
            step(a, $urandom, r, rd, t);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
